// File: rtl/bip_run_ctrl.sv
// bip_run_ctrl: run/step controller and data-RAM arbiter for the BIP core.
// Gates the processor with a registered run-enable, detects halt, counts
// enabled cycles and takes over the data-RAM port to stream a memory dump
// back to the host while the core is stopped.
// Optional feature macro: BIP_CYCLE_CNT_EN (enabled-cycle counter on o_cycles;
// when undefined the counter is removed and o_cycles is tied to 0).
module bip_run_ctrl #(
    parameter int BITS       = 16,
    parameter int DTBITS     = 11,
    parameter int DUMP_WORDS = 16,
    parameter int CNT_BITS   = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    output logic                o_cmd_err,
    output logic                o_cpu_en,
    input  logic                i_cpu_halt,
    input  logic                i_cpu_wr,
    input  logic                i_cpu_rd,
    input  logic [DTBITS-1:0]   i_cpu_addr,
    input  logic [BITS-1:0]     i_cpu_wdata,
    output logic                o_ram_we,
    output logic                o_ram_re,
    output logic [DTBITS-1:0]   o_ram_addr,
    output logic [BITS-1:0]     o_ram_wdata,
    input  logic [BITS-1:0]     i_ram_rdata,
    output logic                o_dump_valid,
    output logic [DTBITS-1:0]   o_dump_addr,
    output logic [BITS-1:0]     o_dump_data,
    input  logic                i_dump_ready,
    output logic [CNT_BITS-1:0] o_cycles,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_HALT     = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_OUT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_RUN  = 2'b00,
        C_STEP = 2'b01,
        C_STOP = 2'b10,
        C_DUMP = 2'b11
    } cmd_t;

    localparam logic [DTBITS-1:0] LAST_PTR = DTBITS'(DUMP_WORDS - 1);

    state_t            state, state_n;
    state_t            ret_state, ret_state_n;
    logic [DTBITS-1:0] ptr, ptr_n;
    logic              cmd_err_n;
    logic              out_first;
    logic [BITS-1:0]   data_q;
    logic              cmd_go;
    logic              halt_hit;

    assign cmd_go   = i_cmd_valid && o_cmd_ready;
    assign halt_hit = i_cpu_halt && o_cpu_en;
    assign o_state  = state;

    // Commands are only taken in the states that can act on them right away.
    always_comb begin
        o_cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_HALT);
    end

    // Next-state, dump pointer and command-error decode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_n     = state;
        ret_state_n = ret_state;
        ptr_n       = ptr;
        cmd_err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_go) begin
                    case (cmd_t'(i_cmd))
                        C_RUN:   state_n = S_RUN;
                        C_STEP:  state_n = S_STEP;
                        C_DUMP: begin
                            state_n     = S_DUMP_RD;
                            ret_state_n = S_IDLE;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                // Halt wins over any command arriving in the same cycle.
                if (halt_hit) begin
                    state_n = S_HALT;
                end else if (cmd_go) begin
                    if (cmd_t'(i_cmd) == C_STOP) state_n = S_IDLE;
                    else                         cmd_err_n = 1'b1;
                end
            end
            S_STEP: begin
                state_n = halt_hit ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                if (cmd_go) begin
                    case (cmd_t'(i_cmd))
                        C_DUMP: begin
                            state_n     = S_DUMP_RD;
                            ret_state_n = S_HALT;
                        end
                        C_STOP:  state_n = S_HALT;
                        default: cmd_err_n = 1'b1;
                    endcase
                end
            end
            S_DUMP_RD: begin
                state_n = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (i_dump_ready) begin
                    if (ptr == LAST_PTR) begin
                        state_n = ret_state;
                        ptr_n   = '0;
                    end else begin
                        state_n = S_DUMP_RD;
                        ptr_n   = ptr + DTBITS'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, enable, error pulse and dump capture registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            ptr       <= '0;
            o_cpu_en  <= 1'b0;
            o_cmd_err <= 1'b0;
            out_first <= 1'b0;
            data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            ret_state <= ret_state_n;
            ptr       <= ptr_n;
            o_cpu_en  <= (state_n == S_RUN) || (state_n == S_STEP);
            o_cmd_err <= cmd_err_n;
            out_first <= (state == S_DUMP_RD);
            if (state == S_DUMP_OUT && out_first) data_q <= i_ram_rdata;
        end
    end

    // RAM port mux: processor while enabled, controller during a dump, idle otherwise.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_re    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (state == S_RUN || state == S_STEP) begin
            o_ram_we    = i_cpu_wr;
            o_ram_re    = i_cpu_rd;
            o_ram_addr  = i_cpu_addr;
            o_ram_wdata = i_cpu_wdata;
        end else if (state == S_DUMP_RD) begin
            o_ram_re   = 1'b1;
            o_ram_addr = ptr;
        end
    end

    // Dump word presentation. The read data arrives during the first DUMP_OUT
    // cycle, so it is passed straight through then and taken from the capture
    // register afterwards; this keeps the word stable until the host takes it.
    always_comb begin
        o_dump_valid = (state == S_DUMP_OUT);
        o_dump_addr  = o_dump_valid ? ptr : '0;
        o_dump_data  = '0;
        if (o_dump_valid) o_dump_data = out_first ? i_ram_rdata : data_q;
    end

`ifdef BIP_CYCLE_CNT_EN
    logic [CNT_BITS-1:0] cycles;

    // Saturating count of cycles in which the processor was enabled.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cycles <= '0;
        end else if (o_cpu_en && (cycles != '1)) begin
            cycles <= cycles + CNT_BITS'(1);
        end
    end

    assign o_cycles = cycles;
`else
    assign o_cycles = '0;
`endif

endmodule
